// File: rtl/sad_accumulator_pkg.sv
// +--------------------------------------------------------------------+
// | sad_accumulator_pkg: state encodings and default widths for SAD    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package sad_accumulator_pkg;

  localparam int C_DATAWIDTH = 64;
  localparam int C_LENWIDTH  = 8;
  localparam int C_ACCWIDTH  = 72;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sad_accumulator_if.sv
// +--------------------------------------------------------------------+
// | sad_accumulator_if: operand stream and result handshake bundle     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface sad_accumulator_if
  import sad_accumulator_pkg::*;
#(
  parameter int DATAWIDTH = C_DATAWIDTH,
  parameter int LENWIDTH  = C_LENWIDTH,
  parameter int ACCWIDTH  = C_ACCWIDTH
) ();

  logic                 start;
  logic [LENWIDTH-1:0]  len;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACCWIDTH-1:0]  sad;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output start, len, a, b, in_valid, out_ready,
    input  in_ready, sad, out_valid, busy
  );

  modport slave (
    input  start, len, a, b, in_valid, out_ready,
    output in_ready, sad, out_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/sad_accumulator_sub.sv
// +--------------------------------------------------------------------+
// | sad_accumulator_sub: unsigned subtractor, o_diff = minuend - subtr |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sad_accumulator_sub
  import sad_accumulator_pkg::*;
#(
  parameter int WIDTH = C_DATAWIDTH
) (
  input  wire logic [WIDTH-1:0] i_minuend,
  input  wire logic [WIDTH-1:0] i_subtrahend,
  output logic      [WIDTH-1:0] o_diff
);

  assign o_diff = i_minuend - i_subtrahend;

endmodule

`default_nettype wire

// File: rtl/sad_accumulator.sv
// +--------------------------------------------------------------------+
// | sad_accumulator: sums |a-b| over len samples, then offers the total |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sad_accumulator
  import sad_accumulator_pkg::*;
#(
  parameter int DATAWIDTH = C_DATAWIDTH,
  parameter int LENWIDTH  = C_LENWIDTH,
  parameter int ACCWIDTH  = C_ACCWIDTH
) (
  input wire logic          clk,
  input wire logic          rst,
  sad_accumulator_if.slave  bus
);

  state_t               r_state;
  state_t               w_next;
  logic [LENWIDTH-1:0]  r_remaining;
  logic [ACCWIDTH-1:0]  r_acc;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_a_ge_b;
  logic [DATAWIDTH-1:0] w_minuend;
  logic [DATAWIDTH-1:0] w_subtrahend;
  logic [DATAWIDTH-1:0] w_diff;

  // Swap operands so the single subtractor always yields a non-negative result.
  assign w_a_ge_b     = (bus.a >= bus.b);
  assign w_minuend    = w_a_ge_b ? bus.a : bus.b;
  assign w_subtrahend = w_a_ge_b ? bus.b : bus.a;

  sad_accumulator_sub #(
    .WIDTH (DATAWIDTH)
  ) u_sub (
    .i_minuend    (w_minuend),
    .i_subtrahend (w_subtrahend),
    .o_diff       (w_diff)
  );

  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_in_ready    = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_next = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        w_in_ready = 1'b1;
        if (w_accept && (r_remaining == LENWIDTH'(1))) begin
          w_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_remaining <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_acc       <= '0;
      r_remaining <= bus.len;
    end else if (w_accept) begin
      r_acc       <= r_acc + ACCWIDTH'(w_diff);
      r_remaining <= r_remaining - LENWIDTH'(1);
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.sad      = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_sad_accumulator.sv
// +--------------------------------------------------------------------+
// | tb_sad_accumulator: vector table, corner sequences, random runs    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sad_accumulator;
  import sad_accumulator_pkg::*;

  localparam int DW = 64;
  localparam int LW = 8;
  localparam int AW = 72;
  localparam logic [DW-1:0] C_MAX = {DW{1'b1}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_accumulator_if #(.DATAWIDTH(DW), .LENWIDTH(LW), .ACCWIDTH(AW)) bus ();

  sad_accumulator #(.DATAWIDTH(DW), .LENWIDTH(LW), .ACCWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int                 len;
    logic [3:0][DW-1:0] a;
    logic [3:0][DW-1:0] b;
    logic [AW-1:0]      exp;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] absdiff(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] d;
    d = (x >= y) ? (x - y) : (y - x);
    return AW'(d);
  endfunction

  task automatic do_start(input int l);
    chk("idle_busy", AW'(bus.busy), AW'(0));
    bus.start = 1'b1;
    bus.len   = LW'(l);
    step();
    bus.start = 1'b0;
    chk("start_busy", AW'(bus.busy), AW'(1));
    if (l == 0) begin
      chk("len0_out_valid", AW'(bus.out_valid), AW'(1));
    end else begin
      chk("start_in_ready", AW'(bus.in_ready), AW'(1));
      chk("start_out_valid", AW'(bus.out_valid), AW'(0));
    end
  endtask

  task automatic feed(input logic [DW-1:0] x, input logic [DW-1:0] y, input int gap, input logic stray);
    repeat (gap) begin
      chk("gap_in_ready", AW'(bus.in_ready), AW'(1));
      step();
    end
    chk("feed_in_ready", AW'(bus.in_ready), AW'(1));
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.b        = y;
    bus.start    = stray;
    step();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic finish(input logic [AW-1:0] exp, input int hold, input logic stray);
    chk("done_out_valid", AW'(bus.out_valid), AW'(1));
    chk("done_sad", bus.sad, exp);
    repeat (hold) begin
      bus.start = stray;
      step();
      chk("hold_out_valid", AW'(bus.out_valid), AW'(1));
      chk("hold_sad", bus.sad, exp);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_busy", AW'(bus.busy), AW'(0));
    chk("post_out_valid", AW'(bus.out_valid), AW'(0));
    chk("post_sad", bus.sad, exp);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.len      = LW'(5);
    bus.a        = '0;
    bus.b        = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0].len = 3; tbl[0].a = '0; tbl[0].b = '0;
    tbl[0].a[0] = 10; tbl[0].b[0] = 3;
    tbl[0].a[1] = 3;  tbl[0].b[1] = 10;
    tbl[0].a[2] = 5;  tbl[0].b[2] = 5;
    tbl[0].exp = 72'd14;
    tbl[1].len = 1; tbl[1].a = '0; tbl[1].b = '0;
    tbl[1].a[0] = 9; tbl[1].b[0] = 4;
    tbl[1].exp = 72'd5;
    tbl[2].len = 4; tbl[2].a = '0; tbl[2].b = '0;
    tbl[2].a[1] = 1;     tbl[2].b[1] = 2;
    tbl[2].a[2] = C_MAX; tbl[2].b[2] = 1;
    tbl[2].a[3] = 7;     tbl[2].b[3] = 7;
    tbl[2].exp = 72'h00_FFFF_FFFF_FFFF_FFFF;
    tbl[3].len = 2; tbl[3].a = '0; tbl[3].b = '0;
    tbl[3].b[0] = C_MAX;
    tbl[3].a[1] = C_MAX;
    tbl[3].exp = 72'h01_FFFF_FFFF_FFFF_FFFE;

    // Reset with start held high must leave the block idle.
    repeat (2) begin
      step();
      chk("rst_sad", bus.sad, '0);
      chk("rst_out_valid", AW'(bus.out_valid), AW'(0));
      chk("rst_in_ready", AW'(bus.in_ready), AW'(0));
      chk("rst_busy", AW'(bus.busy), AW'(0));
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    chk("after_rst_busy", AW'(bus.busy), AW'(0));

    for (int i = 0; i < 4; i++) begin
      do_start(tbl[i].len);
      for (int j = 0; j < tbl[i].len; j++) begin
        feed(tbl[i].a[j], tbl[i].b[j], 0, 1'b0);
        if (j < tbl[i].len - 1) chk("tbl_mid_out_valid", AW'(bus.out_valid), AW'(0));
      end
      finish(tbl[i].exp, 0, 1'b0);
    end

    // Gapped input followed by back-pressure.
    do_start(2);
    feed(100, 1, 0, 1'b0);
    feed(0, 7, 3, 1'b0);
    finish(72'd106, 4, 1'b0);

    do_start(0);
    finish('0, 0, 1'b0);

    do_start(255);
    for (int j = 0; j < 255; j++) feed(C_MAX, '0, 0, 1'b0);
    finish(AW'(255) * AW'(C_MAX), 0, 1'b0);

    // Abort mid-run, then a fresh run.
    do_start(4);
    feed(20, 5, 0, 1'b0);
    feed(5, 20, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", AW'(bus.busy), AW'(0));
    chk("abort_in_ready", AW'(bus.in_ready), AW'(0));
    chk("abort_out_valid", AW'(bus.out_valid), AW'(0));
    chk("abort_sad", bus.sad, '0);
    do_start(1);
    feed(9, 4, 0, 1'b0);
    finish(72'd5, 0, 1'b0);

    // Stray starts in ACCUM and DONE, then a run right after the bubble.
    do_start(2);
    feed(50, 8, 0, 1'b1);
    feed(1, 1, 1, 1'b1);
    finish(72'd42, 2, 1'b1);
    do_start(1);
    feed(3, 1, 0, 1'b0);
    finish(72'd2, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int            l;
      logic [AW-1:0] model;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      l     = int'($urandom_range(0, 12));
      model = '0;
      do_start(l);
      for (int j = 0; j < l; j++) begin
        x = {$urandom(), $urandom()};
        y = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
          0: y = x;
          1: x = C_MAX;
          2: y = C_MAX;
          default: ;
        endcase
        model = model + absdiff(x, y);
        feed(x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0);
        if (j < l - 1) begin
          chk("rnd_mid_out_valid", AW'(bus.out_valid), AW'(0));
          chk("rnd_mid_sad", bus.sad, model);
        end
      end
      finish(model, int'($urandom_range(0, 3)), 1'(($urandom() & 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
